// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: control-bundle layout and datapath defaults.
package pipe_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW_DEF = 5;

  localparam int unsigned CTRL_W     = 8;
  localparam int unsigned BRANCH     = 0;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_TO_REG = 2;
  localparam int unsigned ALU_OP_LO  = 3;
  localparam int unsigned ALU_OP_HI  = 4;
  localparam int unsigned MEM_WRITE  = 5;
  localparam int unsigned ALU_SRC    = 6;
  localparam int unsigned REG_WRITE  = 7;

  // Field order mirrors the stall-mux bit order, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       mem_read;
    logic       branch;
  } id_ex_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with hold; reusable for stall/flush statistics.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!hold && inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush/hold and a saturating bubble counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              bubble_in,
  input  logic              valid_in,
  input  logic              branch_in,
  input  logic              mem_read_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_write_in,
  input  logic              alu_src_in,
  input  logic              reg_write_en_in,
  input  logic [1:0]        alu_op_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [REG_AW-1:0] rs1_addr_in,
  input  logic [REG_AW-1:0] rs2_addr_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic [3:0]        funct_in,
  output logic              branch_out,
  output logic              mem_read_out,
  output logic              mem_to_reg_out,
  output logic              mem_write_out,
  output logic              alu_src_out,
  output logic              reg_write_en_out,
  output logic [1:0]        alu_op_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs1_data_out,
  output logic [XLEN-1:0]   rs2_data_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [REG_AW-1:0] rs1_addr_out,
  output logic [REG_AW-1:0] rs2_addr_out,
  output logic [REG_AW-1:0] rd_addr_out,
  output logic [3:0]        funct_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [CTRL_W-1:0] w_ctrl_bits;
  logic              w_load;
  id_ex_ctrl_t       r_ctrl;
  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [REG_AW-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [3:0]        r_funct;

  assign w_ctrl_bits[BRANCH]     = branch_in;
  assign w_ctrl_bits[MEM_READ]   = mem_read_in;
  assign w_ctrl_bits[MEM_TO_REG] = mem_to_reg_in;
  assign w_ctrl_bits[ALU_OP_LO]  = alu_op_in[0];
  assign w_ctrl_bits[ALU_OP_HI]  = alu_op_in[1];
  assign w_ctrl_bits[MEM_WRITE]  = mem_write_in;
  assign w_ctrl_bits[ALU_SRC]    = alu_src_in;
  assign w_ctrl_bits[REG_WRITE]  = reg_write_en_in;

  assign w_load = !flush && !hold;

  // Flush clears the whole entry; controls are taken verbatim since the stall mux already zeroed them.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_funct    <= '0;
    end else if (!hold) begin
      r_ctrl     <= id_ex_ctrl_t'(w_ctrl_bits);
      r_valid    <= valid_in && !bubble_in;
      r_pc       <= pc_in;
      r_rs1_data <= rs1_data_in;
      r_rs2_data <= rs2_data_in;
      r_imm      <= imm_in;
      r_rs1_addr <= rs1_addr_in;
      r_rs2_addr <= rs2_addr_in;
      r_rd_addr  <= rd_addr_in;
      r_funct    <= funct_in;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_load && bubble_in),
    .hold  (hold),
    .count (bubble_count)
  );

  assign branch_out       = r_ctrl.branch;
  assign mem_read_out     = r_ctrl.mem_read;
  assign mem_to_reg_out   = r_ctrl.mem_to_reg;
  assign mem_write_out    = r_ctrl.mem_write;
  assign alu_src_out      = r_ctrl.alu_src;
  assign reg_write_en_out = r_ctrl.reg_write;
  assign alu_op_out       = r_ctrl.alu_op;
  assign valid_out        = r_valid;
  assign pc_out           = r_pc;
  assign rs1_data_out     = r_rs1_data;
  assign rs2_data_out     = r_rs2_data;
  assign imm_out          = r_imm;
  assign rs1_addr_out     = r_rs1_addr;
  assign rs2_addr_out     = r_rs2_addr;
  assign rd_addr_out      = r_rd_addr;
  assign funct_out        = r_funct;

  // An invalid EX entry must never carry live control bits.
  a_ctrl_zero_when_invalid: assert property (
    @(posedge clk) disable iff (rst) !r_valid |-> (r_ctrl == '0)
  );

endmodule
